// File: rtl/goertzel_axil_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_axil_regs_pkg
// Description : Shared AXI4-Lite channel structs, register offsets, response
//               codes and CTRL bit positions for the Goertzel register block.
// Revision    : 1.0 - initial release
// ============================================================================
package goertzel_axil_regs_pkg;

  // Master-to-slave AXI4-Lite channels
  typedef struct packed {
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axi_lite_mosi;

  // Slave-to-master AXI4-Lite channels
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } axi_lite_miso;

  // Register byte offsets
  localparam logic [31:0] REG_CTRL   = 32'h00;
  localparam logic [31:0] REG_STATUS = 32'h04;
  localparam logic [31:0] REG_COEFF  = 32'h08;
  localparam logic [31:0] REG_NSAMP  = 32'h0C;
  localparam logic [31:0] REG_POWER  = 32'h10;
  localparam logic [31:0] REG_IRQ    = 32'h14;

  // Response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // CTRL bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ENABLE_BIT = 1;

  // Channel FSM encodings
  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Byte-lane merge of new data into an existing 32-bit word
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/goertzel_axil_wr_ch.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_axil_wr_ch
// Description : AXI4-Lite write-channel responder. Captures AW and W in any
//               order, emits a one-cycle write strobe once both are held, then
//               issues the B response and waits for bready.
// Revision    : 1.0 - initial release
// ============================================================================
module goertzel_axil_wr_ch
  import goertzel_axil_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  input  logic        wr_slverr
);

  wr_state_e   r_state,   w_state_nxt;
  logic        r_aw_held, w_aw_held_nxt;
  logic        r_w_held,  w_w_held_nxt;
  logic        r_awready, w_awready_nxt;
  logic        r_wready,  w_wready_nxt;
  logic        r_bvalid,  w_bvalid_nxt;
  logic [1:0]  r_bresp,   w_bresp_nxt;
  logic [31:0] r_addr,    w_addr_nxt;
  logic [31:0] r_data,    w_data_nxt;
  logic [3:0]  r_strb,    w_strb_nxt;

  logic w_aw_hs;
  logic w_w_hs;

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;

  // State and channel registers; readies stay low during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_strb    <= w_strb_nxt;
    end
  end

  // Next-state: capture each channel independently, commit once both held
  always_comb begin
    w_state_nxt   = r_state;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_strb_nxt    = r_strb;
    case (r_state)
      W_IDLE: begin
        if (r_aw_held && r_w_held) begin
          w_state_nxt   = W_RESP;
          w_bvalid_nxt  = 1'b1;
          w_bresp_nxt   = wr_slverr ? RESP_SLVERR : RESP_OKAY;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b0;
        end else begin
          if (w_aw_hs) begin
            w_addr_nxt    = awaddr;
            w_aw_held_nxt = 1'b1;
          end
          if (w_w_hs) begin
            w_data_nxt   = wdata;
            w_strb_nxt   = wstrb;
            w_w_held_nxt = 1'b1;
          end
          w_awready_nxt = ~(r_aw_held | w_aw_hs);
          w_wready_nxt  = ~(r_w_held | w_w_hs);
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_nxt   = W_IDLE;
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign wr_en   = (r_state == W_IDLE) & r_aw_held & r_w_held;
  assign wr_addr = r_addr;
  assign wr_data = r_data;
  assign wr_strb = r_strb;

endmodule
`default_nettype wire

// File: rtl/goertzel_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_axil_regs
// Description : AXI4-Lite control/status register block for the Goertzel
//               engine. Holds CTRL/COEFF/NSAMP, reports STATUS/POWER, and
//               returns SLVERR for unmapped word indices.
//               Optional interrupt register enabled by GOERTZEL_AXIL_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module goertzel_axil_regs
  import goertzel_axil_regs_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int NSAMP_W   = 16,
  parameter int NSAMP_RST = 205
) (
  input  logic               clk,
  input  logic               rst,
  input  axi_lite_mosi       s_axil_mosi,
  output axi_lite_miso       s_axil_miso,
  output logic               start_o,
  output logic               enable_o,
  output logic [31:0]        coeff_o,
  output logic [NSAMP_W-1:0] nsamp_o,
  input  logic               busy_i,
  input  logic               done_i,
  input  logic [31:0]        power_i
`ifdef GOERTZEL_AXIL_IRQ_EN
  ,
  output logic               irq_o
`endif
);

  localparam int c_IDX_W = ADDR_W - 2;
  localparam logic [c_IDX_W-1:0] c_IDX_CTRL   = REG_CTRL[ADDR_W-1:2];
  localparam logic [c_IDX_W-1:0] c_IDX_STATUS = REG_STATUS[ADDR_W-1:2];
  localparam logic [c_IDX_W-1:0] c_IDX_COEFF  = REG_COEFF[ADDR_W-1:2];
  localparam logic [c_IDX_W-1:0] c_IDX_NSAMP  = REG_NSAMP[ADDR_W-1:2];
  localparam logic [c_IDX_W-1:0] c_IDX_POWER  = REG_POWER[ADDR_W-1:2];
`ifdef GOERTZEL_AXIL_IRQ_EN
  localparam logic [c_IDX_W-1:0] c_IDX_IRQ    = REG_IRQ[ADDR_W-1:2];
  localparam int                 c_LAST_IDX   = int'(REG_IRQ >> 2);
  localparam int                 c_IRQ_PEND_BIT = 0;
  localparam int                 c_IRQ_MASK_BIT = 1;
`else
  // The IRQ slot is the first unmapped index when the feature is absent
  localparam int                 c_LAST_IDX   = int'(REG_IRQ >> 2) - 1;
`endif

  // ---------------- write channel ----------------
  logic        w_wr_en;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_slverr;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic        w_wr_ok;
  logic        w_awready, w_wready, w_bvalid;
  logic [1:0]  w_bresp;

  goertzel_axil_wr_ch u_wr_ch (
    .clk       (clk),
    .rst       (rst),
    .awaddr    (s_axil_mosi.awaddr),
    .awvalid   (s_axil_mosi.awvalid),
    .awready   (w_awready),
    .wdata     (s_axil_mosi.wdata),
    .wstrb     (s_axil_mosi.wstrb),
    .wvalid    (s_axil_mosi.wvalid),
    .wready    (w_wready),
    .bresp     (w_bresp),
    .bvalid    (w_bvalid),
    .bready    (s_axil_mosi.bready),
    .wr_en     (w_wr_en),
    .wr_addr   (w_wr_addr),
    .wr_data   (w_wr_data),
    .wr_strb   (w_wr_strb),
    .wr_slverr (w_wr_slverr)
  );

  assign w_wr_idx    = w_wr_addr[ADDR_W-1:2];
  assign w_wr_slverr = int'(w_wr_idx) > c_LAST_IDX;
  assign w_wr_ok     = w_wr_en & ~w_wr_slverr;

  // ---------------- register file ----------------
  logic               r_enable;
  logic               r_start;
  logic [31:0]        r_coeff;
  logic [NSAMP_W-1:0] r_nsamp;
  logic [NSAMP_W-1:0] w_nsamp_wr;

  // Byte-lane merge for NSAMP, which may be narrower than the bus word
  always_comb begin
    w_nsamp_wr = r_nsamp;
    for (int i = 0; i < NSAMP_W; i++) begin
      if (w_wr_strb[i/8]) w_nsamp_wr[i] = w_wr_data[i];
    end
  end

  // Register updates from the write strobe; start is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_start  <= 1'b0;
      r_coeff  <= '0;
      r_nsamp  <= NSAMP_W'(NSAMP_RST);
    end else begin
      r_start <= 1'b0;
      if (w_wr_ok) begin
        case (w_wr_idx)
          c_IDX_CTRL: begin
            if (w_wr_strb[0]) begin
              r_enable <= w_wr_data[CTRL_ENABLE_BIT];
              r_start  <= w_wr_data[CTRL_START_BIT];
            end
          end
          c_IDX_COEFF: r_coeff <= apply_wstrb(r_coeff, w_wr_data, w_wr_strb);
          c_IDX_NSAMP: r_nsamp <= w_nsamp_wr;
          default: ;
        endcase
      end
    end
  end

`ifdef GOERTZEL_AXIL_IRQ_EN
  logic r_done_q;
  logic r_irq_pend;
  logic r_irq_mask;
  logic r_irq;
  logic w_done_rise;
  logic w_irq_wr;
  logic w_irq_clr;

  assign w_done_rise = done_i & ~r_done_q;
  assign w_irq_wr    = w_wr_ok & (w_wr_idx == c_IDX_IRQ) & w_wr_strb[0];
  assign w_irq_clr   = w_irq_wr & w_wr_data[c_IRQ_PEND_BIT];

  // Pending latches done_i rising edges; a same-cycle set beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_irq_mask <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_done_q   <= done_i;
      r_irq_pend <= w_done_rise | (r_irq_pend & ~w_irq_clr);
      if (w_irq_wr) r_irq_mask <= w_wr_data[c_IRQ_MASK_BIT];
      r_irq      <= r_irq_pend & r_irq_mask;
    end
  end

  assign irq_o = r_irq;
`endif

  // ---------------- read channel ----------------
  rd_state_e          r_rd_state, w_rd_state_nxt;
  logic               r_arready,  w_arready_nxt;
  logic               r_rvalid,   w_rvalid_nxt;
  logic [31:0]        r_rdata,    w_rdata_nxt;
  logic [1:0]         r_rresp,    w_rresp_nxt;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic [31:0]        w_rd_val;
  logic [1:0]         w_rd_resp;

  assign w_rd_idx = s_axil_mosi.araddr[ADDR_W-1:2];

  // Read-data mux; unmapped indices give zero data with SLVERR
  always_comb begin
    w_rd_val  = '0;
    w_rd_resp = RESP_OKAY;
    if (int'(w_rd_idx) > c_LAST_IDX) begin
      w_rd_resp = RESP_SLVERR;
    end else begin
      case (w_rd_idx)
        c_IDX_CTRL:   w_rd_val[CTRL_ENABLE_BIT] = r_enable;
        c_IDX_STATUS: w_rd_val[1:0] = {done_i, busy_i};
        c_IDX_COEFF:  w_rd_val = r_coeff;
        c_IDX_NSAMP:  w_rd_val = 32'(r_nsamp);
        c_IDX_POWER:  w_rd_val = power_i;
`ifdef GOERTZEL_AXIL_IRQ_EN
        c_IDX_IRQ: begin
          w_rd_val[c_IRQ_PEND_BIT] = r_irq_pend;
          w_rd_val[c_IRQ_MASK_BIT] = r_irq_mask;
        end
`endif
        default: ;
      endcase
    end
  end

  // Read FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_arready  <= w_arready_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rresp    <= w_rresp_nxt;
    end
  end

  // Read FSM next-state: sample on AR handshake, hold until rready
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_arready_nxt  = r_arready;
    w_rvalid_nxt   = r_rvalid;
    w_rdata_nxt    = r_rdata;
    w_rresp_nxt    = r_rresp;
    case (r_rd_state)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (s_axil_mosi.arvalid && r_arready) begin
          w_arready_nxt  = 1'b0;
          w_rvalid_nxt   = 1'b1;
          w_rdata_nxt    = w_rd_val;
          w_rresp_nxt    = w_rd_resp;
          w_rd_state_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_mosi.rready) begin
          w_rvalid_nxt   = 1'b0;
          w_arready_nxt  = 1'b1;
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Bus response assembly
  always_comb begin
    s_axil_miso         = '0;
    s_axil_miso.awready = w_awready;
    s_axil_miso.wready  = w_wready;
    s_axil_miso.bvalid  = w_bvalid;
    s_axil_miso.bresp   = w_bresp;
    s_axil_miso.arready = r_arready;
    s_axil_miso.rvalid  = r_rvalid;
    s_axil_miso.rdata   = r_rdata;
    s_axil_miso.rresp   = r_rresp;
  end

  assign start_o  = r_start;
  assign enable_o = r_enable;
  assign coeff_o  = r_coeff;
  assign nsamp_o  = r_nsamp;

  // Address bits outside the decoded window and the prot fields are don't-care
  logic w_unused;
  assign w_unused = ^{s_axil_mosi, w_wr_addr};

endmodule
`default_nettype wire

// File: tb/tb_goertzel_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_goertzel_axil_regs
// Description : Self-checking bench for goertzel_axil_regs: directed cases
//               followed by randomized traffic against a register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_goertzel_axil_regs;
  import goertzel_axil_regs_pkg::*;

`ifdef GOERTZEL_AXIL_IRQ_EN
  localparam int c_LAST = 5;
`else
  localparam int c_LAST = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        busy_i = 1'b0, done_i = 1'b0;
  logic [31:0] power_i = '0;

  axi_lite_mosi mosi;
  axi_lite_miso miso;
  logic        start_o, enable_o;
  logic [31:0] coeff_o;
  logic [15:0] nsamp_o;
`ifdef GOERTZEL_AXIL_IRQ_EN
  logic        irq_o;
`endif

  always_comb begin
    mosi         = '0;
    mosi.awaddr  = awaddr;
    mosi.awprot  = 3'b010;
    mosi.awvalid = awvalid;
    mosi.wdata   = wdata;
    mosi.wstrb   = wstrb;
    mosi.wvalid  = wvalid;
    mosi.bready  = bready;
    mosi.araddr  = araddr;
    mosi.arprot  = 3'b001;
    mosi.arvalid = arvalid;
    mosi.rready  = rready;
  end

  goertzel_axil_regs dut (
    .clk         (clk),
    .rst         (rst),
    .s_axil_mosi (mosi),
    .s_axil_miso (miso),
    .start_o     (start_o),
    .enable_o    (enable_o),
    .coeff_o     (coeff_o),
    .nsamp_o     (nsamp_o),
    .busy_i      (busy_i),
    .done_i      (done_i),
    .power_i     (power_i)
`ifdef GOERTZEL_AXIL_IRQ_EN
    ,
    .irq_o       (irq_o)
`endif
  );

  // Reference model state
  logic        m_enable;
  logic [31:0] m_coeff;
  logic [15:0] m_nsamp;
  logic        m_irq_pend, m_irq_mask;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_enable   = 1'b0;
    m_coeff    = 32'h0;
    m_nsamp    = 16'd205;
    m_irq_pend = 1'b0;
    m_irq_mask = 1'b0;
  endtask

  // Word index from the low 8 address bits
  function automatic int widx(input logic [31:0] a);
    return int'(a[7:0]) / 4;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic exp_start);
    int idx;
    logic [31:0] tmp;
    idx       = widx(addr);
    exp_start = 1'b0;
    resp      = 2'b00;
    if (idx > c_LAST) begin
      resp = 2'b10;
      return;
    end
    case (idx)
      0: if (strb[0]) begin
           m_enable  = data[1];
           exp_start = data[0];
         end
      2: for (int b = 0; b < 4; b++) if (strb[b]) m_coeff[8*b +: 8] = data[8*b +: 8];
      3: begin
           tmp = {16'h0, m_nsamp};
           for (int b = 0; b < 4; b++) if (strb[b]) tmp[8*b +: 8] = data[8*b +: 8];
           m_nsamp = tmp[15:0];
         end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, output logic [1:0] resp);
    int idx;
    idx  = widx(addr);
    resp = 2'b00;
    if (idx > c_LAST) begin
      resp = 2'b10;
      return 32'h0;
    end
    case (idx)
      0: return m_enable ? 32'h2 : 32'h0;
      1: return (busy_i ? 32'h1 : 32'h0) + (done_i ? 32'h2 : 32'h0);
      2: return m_coeff;
      3: return 32'(m_nsamp);
      4: return power_i;
      5: return (m_irq_pend ? 32'h1 : 32'h0) + (m_irq_mask ? 32'h2 : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_enable"}, 32'(enable_o), 32'(m_enable));
    check({tag, "_coeff"},  coeff_o, m_coeff);
    check({tag, "_nsamp"},  32'(nsamp_o), 32'(m_nsamp));
  endtask

  // Full write transaction with independent AW/W launch delays and B back-pressure
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awd, input int wd, input int bd);
    logic [1:0] eresp;
    logic       estart;
    bit         aw_done, w_done;
    int         cyc;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    model_write(addr, data, strb, eresp, estart);
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      check("bvalid_before_accept", 32'(miso.bvalid), 32'h0);
      if (aw_done) check("awready_drop", 32'(miso.awready), 32'h0);
      if (w_done)  check("wready_drop",  32'(miso.wready),  32'h0);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && cyc >= awd;
      wvalid  = !w_done && cyc >= wd;
      if (awvalid && miso.awready) aw_done = 1;
      if (wvalid && miso.wready)   w_done  = 1;
      cyc++;
    end
    check("aw_w_accept", 32'(aw_done && w_done), 32'h1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid_not_yet", 32'(miso.bvalid), 32'h0);
    @(negedge clk);
    check("bvalid_latency", 32'(miso.bvalid), 32'h1);
    cyc = 0;
    while (!miso.bvalid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("bresp", 32'(miso.bresp), 32'(eresp));
    check("start_pulse", 32'(start_o), 32'(estart));
    check_outputs("wr");
    for (int i = 0; i < bd; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(miso.bvalid), 32'h1);
      check("bresp_hold", 32'(miso.bresp), 32'(eresp));
      check("awready_hold", 32'(miso.awready), 32'h0);
      check("start_single", 32'(start_o), 32'h0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clear", 32'(miso.bvalid), 32'h0);
    check("awready_back", 32'(miso.awready), 32'h1);
    check("wready_back", 32'(miso.wready), 32'h1);
    check("start_done", 32'(start_o), 32'h0);
  endtask

  // Full read transaction with R back-pressure; inputs wiggle during the hold
  task automatic do_read(input logic [31:0] addr, input int rd);
    logic [31:0] edata;
    logic [1:0]  eresp;
    bit          hs;
    int          cyc;
    hs    = 0;
    cyc   = 0;
    edata = '0;
    eresp = '0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      araddr  = addr;
      arvalid = 1'b1;
      if (miso.arready) begin
        hs    = 1;
        edata = model_read(addr, eresp);
      end
      cyc++;
    end
    check("ar_accept", 32'(hs), 32'h1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_latency", 32'(miso.rvalid), 32'h1);
    check("rdata", miso.rdata, edata);
    check("rresp", 32'(miso.rresp), 32'(eresp));
    check("arready_drop", 32'(miso.arready), 32'h0);
    for (int i = 0; i < rd; i++) begin
      busy_i  = 1'($urandom);
      power_i = $urandom;
      @(negedge clk);
      check("rvalid_hold", 32'(miso.rvalid), 32'h1);
      check("rdata_hold", miso.rdata, edata);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_clear", 32'(miso.rvalid), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_coeff, new_coeff, a, d;
    int idx;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(miso.awready), 32'h0);
    check("rst_arready", 32'(miso.arready), 32'h0);
    check("rst_bvalid", 32'(miso.bvalid), 32'h0);
    check("rst_rvalid", 32'(miso.rvalid), 32'h0);
    check("rst_rdata", miso.rdata, 32'h0);
    check("rst_start", 32'(start_o), 32'h0);
    check_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(miso.awready), 32'h1);
    check("post_rst_wready", 32'(miso.wready), 32'h1);
    check("post_rst_arready", 32'(miso.arready), 32'h1);

    // COEFF with AW and W together
    do_write(32'h08, 32'h3A5B1C2D, 4'hF, 0, 0, 0);
    do_read(32'h08, 0);
    // W three cycles ahead of AW, partial strobe into NSAMP
    do_write(32'h0C, 32'hFFFF_FFFF, 4'b0011, 3, 0, 1);
    do_read(32'h0C, 1);
    // CTRL start + enable
    do_write(32'h00, 32'h3, 4'h1, 0, 1, 0);
    do_read(32'h00, 0);
    // Unmapped and read-only targets
    do_read(32'h40, 0);
    do_write(32'h40, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);
    do_write(32'h04, 32'h3, 4'hF, 0, 0, 0);
    do_write(32'h10, 32'h1234_5678, 4'hF, 0, 2, 0);
    busy_i  = 1'b1;
    power_i = 32'hCAFE_F00D;
    do_read(32'h10, 0);
    do_read(32'h04, 0);
    busy_i  = 1'b0;

`ifdef GOERTZEL_AXIL_IRQ_EN
    done_i = 1'b0;
    do_write(32'h14, 32'h2, 4'hF, 0, 0, 0);
    m_irq_mask = 1'b1;
    @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_set", 32'(irq_o), 32'h1);
    do_write(32'h14, 32'h3, 4'hF, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("irq_clear", 32'(irq_o), 32'h0);
    // Clear coinciding with a done_i rising edge
    @(negedge clk);
    awaddr = 32'h14; wdata = 32'h3; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    done_i  = 1'b1;
    @(negedge clk);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    done_i = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_set_wins", 32'(irq_o), 32'h1);
    m_irq_pend = 1'b1;
    do_read(32'h14, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      busy_i  = 1'($urandom);
      done_i  = 1'($urandom);
      power_i = $urandom;
      idx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(0, 63));
`ifdef GOERTZEL_AXIL_IRQ_EN
      if (idx == 5) idx = 2;
`endif
      a = ($urandom & 32'hFFFF_FF00) | 32'(idx * 4) | 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      else
        do_read(a, int'($urandom_range(0, 3)));
    end
    busy_i = 1'b0;
    done_i = 1'b0;

    // Same-cycle read/write to COEFF, then back-pressure and reset mid-hold
    old_coeff = m_coeff;
    new_coeff = $urandom;
    @(negedge clk);
    awaddr = 32'h08; wdata = new_coeff; wstrb = 4'hF; araddr = 32'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_same_rvalid", 32'(miso.rvalid), 32'h1);
    check("rw_same_old", miso.rdata, old_coeff);
    @(negedge clk);
    m_coeff = new_coeff;
    check("rw_same_bvalid", 32'(miso.bvalid), 32'h1);
    check("rw_same_coeff", coeff_o, m_coeff);
    awaddr = 32'h00; wdata = 32'h3; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_bvalid", 32'(miso.bvalid), 32'h1);
      check("hold_rvalid", 32'(miso.rvalid), 32'h1);
      check("hold_rdata", miso.rdata, old_coeff);
      check("hold_no_accept", {29'h0, miso.awready, miso.wready, miso.arready}, 32'h0);
    end
    check("hold_enable", 32'(enable_o), 32'(m_enable));
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    model_reset();
    check("midrst_valids", {30'h0, miso.bvalid, miso.rvalid}, 32'h0);
    check("midrst_rdata", miso.rdata, 32'h0);
    check("midrst_resp", {28'h0, miso.bresp, miso.rresp}, 32'h0);
    check("midrst_start", 32'(start_o), 32'h0);
    check_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_readies", {29'h0, miso.awready, miso.wready, miso.arready}, 32'h7);
    do_read(32'h08, 0);
    do_read(32'h0C, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
